// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: FSM states, opcode/condition encodings,
// instruction field positions and the condition evaluation shared with the ALU.
package control_unit_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StWriteback,
        StHalt
    } state_e;

    typedef enum logic [3:0] {
        OpAdd  = 4'h0,
        OpSub  = 4'h1,
        OpAnd  = 4'h2,
        OpOrr  = 4'h3,
        OpEor  = 4'h4,
        OpMov  = 4'h5,
        OpMul  = 4'h6,
        OpMvn  = 4'h7,
        OpCmp  = 4'h8,
        OpTst  = 4'h9,
        OpTeq  = 4'hA,
        OpIll0 = 4'hB,
        OpIll1 = 4'hC,
        OpIll2 = 4'hD,
        OpIll3 = 4'hE,
        OpNop  = 4'hF
    } op_e;

    typedef enum logic [3:0] {
        CondAl = 4'h0,
        CondEq = 4'h1,
        CondGt = 4'h2,
        CondLt = 4'h3,
        CondGe = 4'h4,
        CondLe = 4'h5,
        CondHi = 4'h6,
        CondLo = 4'h7,
        CondHs = 4'h8
    } cond_e;

    localparam int unsigned CondLsb = 28;
    localparam int unsigned OpLsb   = 24;
    localparam int unsigned SbitPos = 23;
    localparam int unsigned SrLsb   = 20;
    localparam int unsigned RdLsb   = 16;
    localparam int unsigned RnLsb   = 12;
    localparam int unsigned RmLsb   = 8;
    localparam int unsigned ImmLsb  = 0;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  cond;
        logic [3:0]  opcode;
        logic [3:0]  inflags;
        logic [2:0]  srcontrol;
        logic        sbit;
        logic [15:0] imvalue;
    } alu_req_t;

    // flags are {N,Z,C,V}
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (cond)
            CondEq:  return z;
            CondGt:  return !z && (n == v);
            CondLt:  return n != v;
            CondGe:  return n == v;
            CondLe:  return z || (n != v);
            CondHi:  return c && !z;
            CondLo:  return !c;
            CondHs:  return c;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic is_halt_op(input logic [3:0] op);
        return (op >= OpIll0) && (op <= OpIll3);
    endfunction

    function automatic logic writes_reg(input logic [3:0] op);
        return op <= OpMvn;
    endfunction

    function automatic logic sbit_flag_op(input logic [3:0] op);
        return op <= OpMov;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction-memory, register-file and ALU signals between the control unit and its
// environment. The master side belongs to the control unit.
interface control_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic [3:0]  rf_raddr1;
    logic [3:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_cond;
    logic [3:0]  alu_opcode;
    logic [3:0]  alu_inflags;
    logic [2:0]  alu_srcontrol;
    logic        alu_sbit;
    logic [15:0] alu_imvalue;
    logic [31:0] alu_result;
    logic [3:0]  alu_outflags;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output rf_raddr1, rf_raddr2,
        input  rf_rdata1, rf_rdata2,
        output rf_we, rf_waddr, rf_wdata,
        output alu_in1, alu_in2, alu_cond, alu_opcode, alu_inflags, alu_srcontrol,
        output alu_sbit, alu_imvalue,
        input  alu_result, alu_outflags
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  rf_raddr1, rf_raddr2,
        output rf_rdata1, rf_rdata2,
        input  rf_we, rf_waddr, rf_wdata,
        input  alu_in1, alu_in2, alu_cond, alu_opcode, alu_inflags, alu_srcontrol,
        input  alu_sbit, alu_imvalue,
        output alu_result, alu_outflags
    );
endinterface

// File: rtl/cond_check.sv
// Condition-code check: decides whether an instruction's cond field passes the flags.
module cond_check
    import control_unit_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       met_o
);
    assign met_o = cond_eval(cond_i, flags_i);
endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetch, decode, execute, writeback sequencing around an
// external instruction memory, register file and ALU.
module control_unit
    import control_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              reset,
    control_unit_if.master    bus,
    output logic [31:0]       pc,
    output logic [3:0]        flags,
    output logic              halted
);
    state_e      state_q, state_d;
    logic        started_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [3:0]  flags_q, flags_d;
    logic [31:0] res_q, res_d;
    logic [3:0]  oflags_q, oflags_d;
    // The ALU request register doubles as the operand register, so alu_* hold between uses
    alu_req_t    alu_q, alu_d;

    logic [3:0]  f_cond, f_op, f_rd, f_rn, f_rm;
    logic [2:0]  f_sr;
    logic        f_sbit;
    logic [15:0] f_imm;
    logic        cond_met;

    assign f_cond = ir_q[CondLsb +: 4];
    assign f_op   = ir_q[OpLsb +: 4];
    assign f_sbit = ir_q[SbitPos];
    assign f_sr   = ir_q[SrLsb +: 3];
    assign f_rd   = ir_q[RdLsb +: 4];
    assign f_rn   = ir_q[RnLsb +: 4];
    assign f_rm   = ir_q[RmLsb +: 4];
    assign f_imm  = ir_q[ImmLsb +: 16];

    cond_check u_cond_check (
        .cond_i  (f_cond),
        .flags_i (flags_q),
        .met_o   (cond_met)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        flags_d      = flags_q;
        res_d        = res_q;
        oflags_d     = oflags_q;
        alu_d        = alu_q;
        bus.imem_req = 1'b0;
        bus.rf_we    = 1'b0;

        unique case (state_q)
            StFetch: begin
                // No request until the first clock after reset release
                bus.imem_req = started_q;
                if (started_q && bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (is_halt_op(f_op)) begin
                    state_d = StHalt;
                end else begin
                    alu_d.in1       = bus.rf_rdata1;
                    alu_d.in2       = bus.rf_rdata2;
                    alu_d.cond      = f_cond;
                    alu_d.opcode    = f_op;
                    alu_d.inflags   = flags_q;
                    alu_d.srcontrol = f_sr;
                    alu_d.sbit      = f_sbit;
                    alu_d.imvalue   = f_imm;
                    state_d         = StExecute;
                end
            end
            StExecute: begin
                res_d    = bus.alu_result;
                oflags_d = bus.alu_outflags;
                state_d  = StWriteback;
            end
            StWriteback: begin
                if (cond_met) begin
                    bus.rf_we = writes_reg(f_op);
                    if (f_op == OpCmp || (f_sbit && sbit_flag_op(f_op))) begin
                        flags_d = oflags_q;
                    end
                end
                pc_d    = pc_q + 32'(PC_STEP);
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            started_q <= 1'b0;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            flags_q   <= '0;
            res_q     <= '0;
            oflags_q  <= '0;
            alu_q     <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            flags_q   <= flags_d;
            res_q     <= res_d;
            oflags_q  <= oflags_d;
            alu_q     <= alu_d;
        end
    end

    assign bus.imem_addr     = pc_q;
    assign bus.rf_raddr1     = f_rn;
    assign bus.rf_raddr2     = f_rm;
    assign bus.rf_waddr      = f_rd;
    assign bus.rf_wdata      = res_q;
    assign bus.alu_in1       = alu_q.in1;
    assign bus.alu_in2       = alu_q.in2;
    assign bus.alu_cond      = alu_q.cond;
    assign bus.alu_opcode    = alu_q.opcode;
    assign bus.alu_inflags   = alu_q.inflags;
    assign bus.alu_srcontrol = alu_q.srcontrol;
    assign bus.alu_sbit      = alu_q.sbit;
    assign bus.alu_imvalue   = alu_q.imvalue;

    assign pc     = pc_q;
    assign flags  = flags_q;
    assign halted = (state_q == StHalt);
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: bench-side register file and ALU, hand-computed
// expectations for each instruction sequence.
module tb_control_unit;
    logic        clk;
    logic        reset;
    logic [31:0] pc, pc2;
    logic [3:0]  flags, flags2;
    logic        halted, halted2;

    control_unit_if ifc ();
    control_unit_if ifc2 ();

    control_unit u_dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (ifc.master),
        .pc     (pc),
        .flags  (flags),
        .halted (halted)
    );

    // Second instance starts just below the 32-bit limit to exercise PC wrap
    control_unit #(
        .RESET_PC (32'hFFFF_FFFC),
        .PC_STEP  (4)
    ) u_dut_wrap (
        .clk    (clk),
        .reset  (reset),
        .bus    (ifc2.master),
        .pc     (pc2),
        .flags  (flags2),
        .halted (halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rf [16];
    assign ifc.rf_rdata1 = rf[ifc.rf_raddr1];
    assign ifc.rf_rdata2 = rf[ifc.rf_raddr2];

    // Bench ALU: ADD, SUB/CMP with borrow-style carry; everything else passes in2
    logic [32:0] alu_sum;
    logic [31:0] alu_res;
    logic        alu_c, alu_v;
    always_comb begin
        alu_sum = '0;
        alu_res = ifc.alu_in2;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ifc.alu_opcode)
            4'h0: begin
                alu_sum = {1'b0, ifc.alu_in1} + {1'b0, ifc.alu_in2};
                alu_res = alu_sum[31:0];
                alu_c   = alu_sum[32];
                alu_v   = (ifc.alu_in1[31] == ifc.alu_in2[31]) && (alu_res[31] != ifc.alu_in1[31]);
            end
            4'h1, 4'h8: begin
                alu_sum = {1'b0, ifc.alu_in1} + {1'b0, ~ifc.alu_in2} + 33'd1;
                alu_res = alu_sum[31:0];
                alu_c   = alu_sum[32];
                alu_v   = (ifc.alu_in1[31] != ifc.alu_in2[31]) && (alu_res[31] != ifc.alu_in1[31]);
            end
            default: ;
        endcase
    end
    assign ifc.alu_result   = alu_res;
    assign ifc.alu_outflags = {alu_res[31], alu_res == 32'h0, alu_c, alu_v};

    assign ifc2.imem_ack     = 1'b1;
    assign ifc2.imem_rdata   = 32'h0F00_0000;
    assign ifc2.rf_rdata1    = '0;
    assign ifc2.rf_rdata2    = '0;
    assign ifc2.alu_result   = '0;
    assign ifc2.alu_outflags = '0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (ifc.imem_req !== 1'b1 && n < 10) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check_eq("wait_req", ifc.imem_req, 1'b1);
    endtask

    // Called at a negedge in FETCH with imem_req high; returns at the negedge after retire
    task automatic do_instr(input logic [31:0] instr, input int delay, input logic stray,
                            output int cycles, output int we_cnt,
                            output logic [3:0] waddr, output logic [31:0] wdata);
        logic [31:0] pc0;
        pc0    = pc;
        cycles = 0;
        we_cnt = 0;
        waddr  = '0;
        wdata  = '0;
        for (int i = 0; i < delay; i++) begin
            ifc.imem_ack = 1'b0;
            @(posedge clk);
            cycles++;
            @(negedge clk);
            check_eq("req_held", ifc.imem_req, 1'b1);
            check_eq("addr_stable", ifc.imem_addr, pc0);
        end
        ifc.imem_ack   = 1'b1;
        ifc.imem_rdata = instr;
        @(posedge clk);
        cycles++;
        @(negedge clk);
        ifc.imem_ack = 1'b0;
        while (pc == pc0 && cycles < 20) begin
            if (stray) begin
                ifc.imem_ack   = 1'b1;
                ifc.imem_rdata = 32'h0C0F_0000;
            end
            if (ifc.rf_we === 1'b1) begin
                we_cnt++;
                waddr = ifc.rf_waddr;
                wdata = ifc.rf_wdata;
            end
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        ifc.imem_ack = 1'b0;
    endtask

    int          cyc, wec;
    logic [3:0]  wa;
    logic [31:0] wd;
    int          req_seen;

    initial begin
        @(posedge reset);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("wrap_pc_before", pc2, 32'hFFFF_FFFC);
        @(posedge clk);
        @(negedge clk);
        check_eq("wrap_pc_after", pc2, 32'h0000_0000);
    end

    initial begin
        reset          = 1'b0;
        ifc.imem_ack   = 1'b0;
        ifc.imem_rdata = '0;
        for (int i = 0; i < 16; i++) rf[i] = '0;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        repeat (2) @(negedge clk);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_flags", flags, 4'h0);
        check_eq("rst_halted", halted, 1'b0);
        check_eq("rst_req", ifc.imem_req, 1'b0);
        check_eq("rst_we", ifc.rf_we, 1'b0);
        check_eq("rst_alu_in1", ifc.alu_in1, 32'h0);
        reset = 1'b1;
        #1;
        check_eq("req_after_release", ifc.imem_req, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_eq("req_first_edge", ifc.imem_req, 1'b1);
        check_eq("first_addr", ifc.imem_addr, 32'h0);

        // ADD r3 = r1 + r2
        do_instr(32'h0003_1200, 0, 1'b0, cyc, wec, wa, wd);
        check_eq("add_cycles", cyc, 4);
        check_eq("add_we", wec, 1);
        check_eq("add_waddr", wa, 4'd3);
        check_eq("add_wdata", wd, 32'd12);
        check_eq("add_pc", pc, 32'd4);

        // CMP 9,9 then ADDEQ r4
        rf[1] = 32'd9;
        rf[2] = 32'd9;
        do_instr(32'h0800_1200, 0, 1'b0, cyc, wec, wa, wd);
        check_eq("cmp_eq_flags", flags, 4'b0110);
        check_eq("cmp_eq_we", wec, 0);
        do_instr(32'h1004_1200, 0, 1'b0, cyc, wec, wa, wd);
        check_eq("addeq_we", wec, 1);
        check_eq("addeq_waddr", wa, 4'd4);
        check_eq("addeq_wdata", wd, 32'd18);

        // CMP 9,8 then ADDEQ skipped
        rf[2] = 32'd8;
        do_instr(32'h0800_1200, 0, 1'b0, cyc, wec, wa, wd);
        check_eq("cmp_ne_flags", flags, 4'b0010);
        do_instr(32'h1004_1200, 0, 1'b0, cyc, wec, wa, wd);
        check_eq("addeq_skip_we", wec, 0);
        check_eq("addeq_skip_flags", flags, 4'b0010);
        check_eq("addeq_skip_pc", pc, 32'd20);

        // SUB 3-5 without then with S bit
        rf[1] = 32'd3;
        rf[2] = 32'd5;
        do_instr(32'h0105_1200, 0, 1'b0, cyc, wec, wa, wd);
        check_eq("sub_nos_flags", flags, 4'b0010);
        check_eq("sub_nos_wdata", wd, 32'hFFFF_FFFE);
        do_instr(32'h0185_1200, 0, 1'b0, cyc, wec, wa, wd);
        check_eq("subs_flags", flags, 4'b1000);
        check_eq("subs_waddr", wa, 4'd5);
        check_eq("alu_in1_hold", ifc.alu_in1, 32'd3);
        check_eq("alu_in2_hold", ifc.alu_in2, 32'd5);
        check_eq("alu_op_hold", ifc.alu_opcode, 4'h1);
        check_eq("alu_sbit_hold", ifc.alu_sbit, 1'b1);
        check_eq("alu_inflags", ifc.alu_inflags, 4'b0010);

        // ADD r6 with ack delayed 3 cycles and stray acks after fetch
        do_instr(32'h0006_1200, 3, 1'b1, cyc, wec, wa, wd);
        check_eq("delay_cycles", cyc, 7);
        check_eq("delay_we", wec, 1);
        check_eq("delay_waddr", wa, 4'd6);
        check_eq("delay_wdata", wd, 32'd8);
        check_eq("delay_pc", pc, 32'd32);
        check_eq("delay_flags", flags, 4'b1000);

        // Illegal opcode 1100 halts
        wait_req();
        ifc.imem_ack   = 1'b1;
        ifc.imem_rdata = 32'h0C00_0000;
        @(posedge clk);
        @(negedge clk);
        ifc.imem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("halted", halted, 1'b1);
        req_seen = 0;
        for (int i = 0; i < 4; i++) begin
            ifc.imem_ack = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (ifc.imem_req !== 1'b0 || ifc.rf_we !== 1'b0) req_seen++;
        end
        ifc.imem_ack = 1'b0;
        check_eq("halt_no_req", req_seen, 0);
        check_eq("halt_pc", pc, 32'd32);
        check_eq("halt_flags", flags, 4'b1000);

        reset = 1'b0;
        #1;
        check_eq("halt_rst_halted", halted, 1'b0);
        check_eq("halt_rst_pc", pc, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // SUBS interrupted by reset in WRITEBACK
        wait_req();
        ifc.imem_ack   = 1'b1;
        ifc.imem_rdata = 32'h0185_1200;
        @(posedge clk);
        @(negedge clk);
        ifc.imem_ack = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("wb_we_before_rst", ifc.rf_we, 1'b1);
        reset = 1'b0;
        #1;
        check_eq("wb_rst_we", ifc.rf_we, 1'b0);
        check_eq("wb_rst_pc", pc, 32'h0);
        check_eq("wb_rst_flags", flags, 4'h0);
        check_eq("wb_rst_alu_in1", ifc.alu_in1, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check_eq("wb_rst_flags_held", flags, 4'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 4, PC increment per retired instruction.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: imem_req  out  1  fetch request; imem_addr  out  32  fetch address (= PC); imem_ack  in  1  fetch data valid; imem_rdata  in  32  instruction word.
REQ-005 SHALL have ports: rf_raddr1, rf_raddr2  out  4  register read addresses; rf_rdata1, rf_rdata2  in  32  read data, combinational.
REQ-006 SHALL have ports: rf_we  out  1  write enable; rf_waddr  out  4  write address; rf_wdata  out  32  write data.
REQ-007 SHALL have ALU-side outputs: alu_in1, alu_in2 (32), alu_cond, alu_opcode, alu_inflags (4), alu_srcontrol (3), alu_sbit (1), alu_imvalue (16).
REQ-008 SHALL have ALU-side inputs: alu_result  32  operation result; alu_outflags  4  {N,Z,C,V}.
REQ-009 SHALL have outputs: pc  32  current PC; flags  4  architectural {N,Z,C,V}; halted  1  illegal-opcode stop.

Function
REQ-010 SHALL decode instruction fields: cond=[31:28], opcode=[27:24], sbit=[23], srcontrol=[22:20], rd=[19:16], rn=[15:12], rm=[11:8], imvalue=[15:0].
REQ-011 SHALL implement FSM states FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-012 FETCH: imem_req=1, imem_addr=pc; held until imem_ack=1, then latch imem_rdata into instruction register, go DECODE; imem_req deasserts same edge.
REQ-013 imem_ack while imem_req=0 SHALL be ignored.
REQ-014 DECODE: rf_raddr1=rn, rf_raddr2=rm; latch rf_rdata1/2 into operand registers; opcode 1011-1110 -> HALT, else -> EXECUTE.
REQ-015 EXECUTE: drive all alu_* outputs from latched fields/operands, alu_inflags=flags; latch alu_result and alu_outflags at end of cycle; -> WRITEBACK.
REQ-016 alu_* outputs SHALL be stable for the full EXECUTE cycle and hold last values in other states.
REQ-017 SHALL evaluate cond against flags with the ALU table: 0001 EQ, 0010 GT, 0011 LT, 0100 GE, 0101 LE, 0110 HI, 0111 LO, 1000 HS, others always.
REQ-018 WRITEBACK, cond met, opcode 0000-0111: rf_we=1 one cycle, rf_waddr=rd, rf_wdata=latched result.
REQ-019 WRITEBACK, cond met: flags <= latched outflags if opcode 1000 (CMP), or if sbit=1 and opcode 0000-0101.
REQ-020 Cond not met, or opcode 1001/1010/1111: no register write, no flag change.
REQ-021 WRITEBACK SHALL set pc <= pc + PC_STEP (modulo 2^32, wrap from FFFF_FFFC to 0) and go FETCH.
REQ-022 Retired instruction SHALL take exactly 4 cycles when imem_ack is high in the first FETCH cycle.
REQ-023 HALT: halted=1, all request/write strobes 0, pc and flags frozen; exit only by reset.
REQ-024 rf_we SHALL be 1 only in WRITEBACK.

Reset
REQ-025 reset low SHALL immediately force: state FETCH, pc=RESET_PC, flags=0000, instruction/operand/result registers 0, rf_we=0, halted=0, alu_* outputs 0.
REQ-026 imem_req SHALL be 0 while reset is low and assert on the first rising clk after reset release.
REQ-027 Reset mid-fetch or mid-writeback SHALL abort with no register write or flag update.

Structure
REQ-028 Shared package SHALL hold: state encoding, opcode constants (ADD..NOP), cond constants, field bit positions, and cond-evaluation function used by both ALU and this block.
REQ-029 One sub-module, cond_check (cond, flags -> met), SHALL be instantiated; all else in control_unit.

Verification
REQ-030 ADD, r1=5, r2=7, instr rd=3,rn=1,rm=2,opcode 0000,cond 0000 -> rf_we pulse, waddr 3, wdata 12, pc 0->4 after 4 cycles.
REQ-031 CMP r1=r2=9 then ADDEQ (cond 0001) -> flags Z=1, ADD written; same with r2=8 -> flags Z=0, no write.
REQ-032 SUB sbit=1, 3-5 with ALU flags 1000 -> flags=1000; same with sbit=0 -> flags unchanged.
REQ-033 imem_ack delayed 3 cycles -> imem_req held, imem_addr stable, 7 cycles to retire; stray ack in EXECUTE ignored.
REQ-034 Opcode 1100 -> halted=1, no further imem_req; reset low mid-WRITEBACK -> no write, pc=RESET_PC, flags=0000.
